// File: rtl/i2c_target_mem.sv
// ---------------------------------------------------------------------------
// i2c_target_mem
//   I2C target with an internal byte memory. SCL/SDA are synchronised into
//   the clk domain, START/STOP and SCL edges are detected, the 7-bit device
//   address is matched and ACKed. A write transfer loads the memory pointer
//   with its first data byte and stores further bytes with auto-increment.
//   A read transfer returns bytes from the pointer with auto-increment.
//
// Ports
//   clk      in   system clock (SCL high/low phases each >= 8 clk periods)
//   rst      in   synchronous, active-high reset
//   scl_i    in   bus SCL level (asynchronous)
//   sda_i    in   bus SDA level (asynchronous)
//   sda_oe   out  1 = pull SDA low, 0 = release
//   busy     out  1 from an address-matched START until STOP
//   wr_stb   out  one-clk pulse per stored data byte
//   wr_addr  out  memory index written (valid with wr_stb)
//   wr_data  out  byte written (valid with wr_stb)
// ---------------------------------------------------------------------------
module i2c_target_mem #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         MEM_DEPTH   = 128,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       busy,
    output logic       wr_stb,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data
);

    localparam int PTR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WPTR,
        S_WPTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RACK,
        S_IGNORE
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic [3:0]             r_bitcnt;
    logic [7:0]             r_shreg;
    logic                   r_rw;
    logic [PTR_W-1:0]       r_ptr;
    logic [7:0]             r_mem [MEM_DEPTH];

    logic                   w_scl_s;
    logic                   w_sda_s;
    logic                   w_scl_rise;
    logic                   w_scl_fall;
    logic                   w_start;
    logic                   w_stop;
    logic [7:0]             w_byte;
    logic [PTR_W-1:0]       w_ptr_inc;
    logic [PTR_W-1:0]       w_ptr_load;

    assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise =  w_scl_s & ~r_scl_prev;
    assign w_scl_fall = ~w_scl_s &  r_scl_prev;
    assign w_start    =  w_scl_s &  r_sda_prev & ~w_sda_s;
    assign w_stop     =  w_scl_s & ~r_sda_prev &  w_sda_s;

    // Byte as it stands once the bit on the current SCL rise is shifted in.
    assign w_byte     = {r_shreg[6:0], w_sda_s};
    assign w_ptr_inc  = (r_ptr == PTR_W'(MEM_DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
    assign w_ptr_load = PTR_W'(32'(w_byte) % MEM_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            // Sync chain starts at the idle bus level so no edge is invented.
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
            r_state    <= S_IDLE;
            r_bitcnt   <= '0;
            r_shreg    <= '0;
            r_rw       <= 1'b0;
            r_ptr      <= '0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            wr_stb     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_prev <= w_scl_s;
            r_sda_prev <= w_sda_s;
            wr_stb     <= 1'b0;

            // Bus conditions win over whatever the byte engine is doing; a
            // partial byte is simply dropped.
            if (w_start) begin
                r_state  <= S_ADDR;
                r_bitcnt <= '0;
                sda_oe   <= 1'b0;
            end else if (w_stop) begin
                r_state  <= S_IDLE;
                busy     <= 1'b0;
                sda_oe   <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shreg <= w_byte;
                            if (r_bitcnt == 4'd7) begin
                                r_bitcnt <= '0;
                                if (w_byte[7:1] == DEV_ADDR) begin
                                    r_state <= S_ADDR_ACK;
                                    r_rw    <= w_byte[0];
                                    busy    <= 1'b1;
                                end else begin
                                    r_state <= S_IGNORE;
                                end
                            end else begin
                                r_bitcnt <= r_bitcnt + 4'd1;
                            end
                        end
                    end

                    // r_bitcnt marks the ACK phase: 0 = waiting for the fall
                    // that starts the ACK, 1 = waiting for the fall that ends it.
                    S_ADDR_ACK, S_WPTR_ACK, S_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            if (r_bitcnt == 4'd0) begin
                                sda_oe   <= 1'b1;
                                r_bitcnt <= 4'd1;
                            end else begin
                                r_bitcnt <= '0;
                                if (r_state == S_ADDR_ACK && r_rw) begin
                                    r_state <= S_RDATA;
                                    r_shreg <= r_mem[r_ptr];
                                    sda_oe  <= ~r_mem[r_ptr][7];
                                end else begin
                                    sda_oe  <= 1'b0;
                                    r_state <= (r_state == S_ADDR_ACK) ? S_WPTR : S_WDATA;
                                end
                            end
                        end
                    end

                    S_WPTR: begin
                        if (w_scl_rise) begin
                            r_shreg <= w_byte;
                            if (r_bitcnt == 4'd7) begin
                                r_bitcnt <= '0;
                                r_ptr    <= w_ptr_load;
                                r_state  <= S_WPTR_ACK;
                            end else begin
                                r_bitcnt <= r_bitcnt + 4'd1;
                            end
                        end
                    end

                    S_WDATA: begin
                        if (w_scl_rise) begin
                            r_shreg <= w_byte;
                            if (r_bitcnt == 4'd7) begin
                                r_bitcnt     <= '0;
                                r_mem[r_ptr] <= w_byte;
                                wr_stb       <= 1'b1;
                                wr_addr      <= 7'(r_ptr);
                                wr_data      <= w_byte;
                                r_ptr        <= w_ptr_inc;
                                r_state      <= S_WDATA_ACK;
                            end else begin
                                r_bitcnt <= r_bitcnt + 4'd1;
                            end
                        end
                    end

                    // MSB is already on the bus when this state is entered;
                    // each rise shifts the next bit up to r_shreg[7].
                    S_RDATA: begin
                        if (w_scl_rise) begin
                            r_shreg  <= {r_shreg[6:0], 1'b0};
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                sda_oe   <= 1'b0;
                                r_bitcnt <= '0;
                                r_state  <= S_RACK;
                            end else begin
                                sda_oe <= ~r_shreg[7];
                            end
                        end
                    end

                    S_RACK: begin
                        if (w_scl_rise) begin
                            r_ptr <= w_ptr_inc;
                            if (!w_sda_s) begin
                                r_state  <= S_RDATA;
                                r_shreg  <= r_mem[w_ptr_inc];
                                r_bitcnt <= '0;
                            end else begin
                                r_state <= S_IGNORE;
                            end
                        end
                    end

                    S_IGNORE: begin
                        sda_oe <= 1'b0;
                    end

                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
